ldl_fifo_rd_arb: RTL and testbench

LDL_FIFO_RD_ARB -- requirements
Module: LDL_fifo_rd_arb

---
 rtl/ldl_fifo_rd_arb.sv | 137 +++++++++++++
 tb/tb_ldl_fifo_rd_arb.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ldl_fifo_rd_arb.sv
// Round-robin read arbiter over N registered FIFOs feeding a 2-entry output buffer.
// Define LDL_FIFO_RD_ARB_STRICT0_EN to give FIFO 0 strict priority over the rotation.
module ldl_fifo_rd_arb #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int QW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    q_empty,
  output logic [N-1:0]    q_re,
  input  logic [N*DW-1:0] q_rdata,
  input  logic [N-1:0]    q_mask,
  input  logic            pause,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [QW-1:0]   out_qid
);

  localparam int unsigned NU = N;

  logic [QW-1:0] rr_ptr_q, rr_ptr_d;
  logic          infl_q, infl_d;
  logic [QW-1:0] infl_id_q, infl_id_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] b0_data_q, b0_data_d, b1_data_q, b1_data_d;
  logic [QW-1:0] b0_qid_q, b0_qid_d, b1_qid_q, b1_qid_d;

  logic [N-1:0]  cand, rr_cand;
  logic [QW-1:0] grant_id;
  logic          found, issue, credit_ok, pop, push;
  logic [DW-1:0] rd_word;
  logic [1:0]    cnt_tmp;
`ifdef LDL_FIFO_RD_ARB_STRICT0_EN
  logic          strict_hit;
`endif

  assign cand      = q_mask & ~q_empty;
  // In-flight read reserves a buffer slot so the buffer cannot overflow.
  assign credit_ok = ({1'b0, cnt_q} + {2'b00, infl_q}) < 3'd2;

  always_comb begin
    int unsigned idx;
    found    = 1'b0;
    grant_id = '0;
    rr_cand  = cand;
`ifdef LDL_FIFO_RD_ARB_STRICT0_EN
    strict_hit = 1'b0;
    rr_cand[0] = 1'b0;
`endif
    for (int unsigned k = 0; k < NU; k++) begin
      idx = (int'(rr_ptr_q) + k) % NU;
      if (!found && rr_cand[idx]) begin
        found    = 1'b1;
        grant_id = QW'(idx);
      end
    end
`ifdef LDL_FIFO_RD_ARB_STRICT0_EN
    if (cand[0]) begin
      found      = 1'b1;
      grant_id   = '0;
      strict_hit = 1'b1;
    end
`endif
  end

  assign issue = rst & found & ~pause & credit_ok;
  assign q_re  = issue ? ({{(N-1){1'b0}}, 1'b1} << grant_id) : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
`ifdef LDL_FIFO_RD_ARB_STRICT0_EN
    if (issue && !strict_hit)
`else
    if (issue)
`endif
      rr_ptr_d = (grant_id == QW'(N - 1)) ? '0 : grant_id + 1'b1;
  end

  // The in-flight word is presented directly from q_rdata while the buffer is empty.
  assign rd_word   = q_rdata[int'(infl_id_q)*DW +: DW];
  assign out_valid = (cnt_q != 2'd0) | infl_q;
  assign out_data  = (cnt_q != 2'd0) ? b0_data_q : (infl_q ? rd_word : '0);
  assign out_qid   = (cnt_q != 2'd0) ? b0_qid_q  : (infl_q ? infl_id_q : '0);
  assign pop       = out_valid & out_ready;
  assign push      = infl_q & ~(pop & (cnt_q == 2'd0));

  always_comb begin
    b0_data_d = b0_data_q;
    b0_qid_d  = b0_qid_q;
    b1_data_d = b1_data_q;
    b1_qid_d  = b1_qid_q;
    cnt_tmp   = cnt_q;
    if (pop && cnt_q != 2'd0) begin
      b0_data_d = b1_data_q;
      b0_qid_d  = b1_qid_q;
      cnt_tmp   = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_tmp == 2'd0) begin
        b0_data_d = rd_word;
        b0_qid_d  = infl_id_q;
      end else begin
        b1_data_d = rd_word;
        b1_qid_d  = infl_id_q;
      end
      cnt_tmp = cnt_tmp + 2'd1;
    end
    cnt_d     = cnt_tmp;
    infl_d    = issue;
    infl_id_d = issue ? grant_id : infl_id_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q  <= '0;
      infl_q    <= 1'b0;
      infl_id_q <= '0;
      cnt_q     <= '0;
      b0_data_q <= '0;
      b0_qid_q  <= '0;
      b1_data_q <= '0;
      b1_qid_q  <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      infl_q    <= infl_d;
      infl_id_q <= infl_id_d;
      cnt_q     <= cnt_d;
      b0_data_q <= b0_data_d;
      b0_qid_q  <= b0_qid_d;
      b1_data_q <= b1_data_d;
      b1_qid_q  <= b1_qid_d;
    end
  end

endmodule

// File: tb/tb_ldl_fifo_rd_arb.sv
// Directed bench for ldl_fifo_rd_arb with registered-FIFO models and an output scoreboard.
module tb_ldl_fifo_rd_arb;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int QW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    q_empty, q_re, q_mask;
  logic [N*DW-1:0] q_rdata;
  logic            pause, out_valid, out_ready;
  logic [DW-1:0]   out_data;
  logic [QW-1:0]   out_qid;

  int checks   = 0;
  int failures = 0;
  int cnt[N];
  int nxt[N];
  logic [QW+DW-1:0] sb[$];

  always #5 clk = ~clk;

  ldl_fifo_rd_arb #(.N(N), .DW(DW), .QW(QW)) dut (
    .clk(clk), .rst(rst), .q_empty(q_empty), .q_re(q_re), .q_rdata(q_rdata),
    .q_mask(q_mask), .pause(pause), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_qid(out_qid)
  );

  function automatic logic [DW-1:0] word(input int i, input int k);
    return DW'((i << 4) | (k & 15));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_empty();
    for (int i = 0; i < N; i++) q_empty[i] = (cnt[i] == 0);
  endtask

  task automatic fill(input int a, input int b, input int c, input int d);
    cnt[0] = a; cnt[1] = b; cnt[2] = c; cnt[3] = d;
    upd_empty();
  endtask

  // One clock: check at negedge, track issues/pops, then advance the FIFO models after the edge.
  task automatic step(input int exp_re, input int exp_ov);
    logic [N-1:0]     re_s;
    logic [QW+DW-1:0] e;
    @(negedge clk);
    if (exp_re >= 0) chk("q_re", 32'(q_re), exp_re);
    if (exp_ov >= 0) chk("out_valid", 32'(out_valid), exp_ov);
    if (out_valid && out_ready) begin
      chk("sb_avail", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_qid", 32'(out_qid), 32'(e[QW+DW-1:DW]));
        chk("out_data", 32'(out_data), 32'(e[DW-1:0]));
      end
    end
    re_s = q_re;
    for (int i = 0; i < N; i++)
      if (re_s[i]) sb.push_back({QW'(i), word(i, nxt[i])});
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (re_s[i]) begin
        q_rdata[i*DW +: DW] = word(i, nxt[i]);
        nxt[i]++;
        if (cnt[i] > 0) cnt[i]--;
      end
    end
    upd_empty();
  endtask

  initial begin
    for (int i = 0; i < N; i++) nxt[i] = 0;
    q_mask = 4'b1111; pause = 1'b0; out_ready = 1'b1; q_rdata = '0;
    fill(8, 8, 8, 8);

    step(0, 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_qid", 32'(out_qid), 0);
    rst = 1'b1;

`ifdef LDL_FIFO_RD_ARB_STRICT0_EN
    fill(3, 3, 3, 3);
    step(1, 0); step(1, 1); step(1, 1);
    step(2, 1); step(4, 1); step(8, 1); step(2, 1);
    q_mask = 4'b0000;
    step(0, 1); step(0, 0);
`else
    // Full rotation with all FIFOs available.
    step(1, 0); step(2, 1); step(4, -1); step(8, -1);
    step(1, -1); step(2, -1); step(4, -1); step(8, -1);

    // FIFOs 1 and 3 empty: alternate 0 and 2.
    cnt[1] = 0; cnt[3] = 0; upd_empty();
    step(1, -1); step(4, -1); step(1, -1); step(4, -1);
    q_mask = 4'b0000;
    step(0, 1); step(0, 0);

    // Stalled consumer: exactly two reads, then drain in order and resume.
    q_mask = 4'b1111; fill(8, 8, 8, 8); out_ready = 1'b0;
    step(8, 0); step(1, 1); step(0, 1); step(0, 1);
    out_ready = 1'b1;
    step(0, 1); step(2, 1); step(4, 1);

    // Pause right after a FIFO 1 grant still delivers that word.
    step(8, 1); step(1, 1); step(2, 1);
    pause = 1'b1;
    step(0, 1); step(0, 0);
    pause = 1'b0;
    step(4, 0);
    q_mask = 4'b0000;
    step(0, 1); step(0, 0);

    // Last word of FIFO 0 is not re-granted once its empty rises.
    q_mask = 4'b1111; fill(1, 0, 0, 0);
    step(1, 0); step(0, 1); step(0, 0);

    // Reset with two buffered words.
    fill(8, 8, 8, 8); out_ready = 1'b0;
    step(2, 0); step(4, 1); step(0, 1);
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_q_re", 32'(q_re), 0);
    sb.delete();
    step(0, 0);
    chk("rst_mid_data", 32'(out_data), 0);
    chk("rst_mid_qid", 32'(out_qid), 0);
    rst = 1'b1; out_ready = 1'b1;
    cnt[0] = 0; upd_empty();
    step(2, 0); step(4, 1); step(8, 1); step(2, 1);
    q_mask = 4'b0000;
    step(0, 1); step(0, 0);
`endif

    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
